ram_bus_master: RTL and testbench

Bus initiator for the 128×32 single-port RAM: it drives the RAM's `addr`, `wre` and bidirectional `data` pins. Load/store requests arrive from the pipeline through a valid/ready port and are buffered in a small FIFO. Each request is sequenced into contention-free RAM cycles, and read data is returned through a one-cycle response strobe. The block sits between the pipeline memory stage and the RAM, with one instance per RAM.

---
 rtl/ram_bus_master.sv | 155 +++++++++++++++
 tb/tb_ram_bus_master.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/ram_bus_master.sv
// Bus initiator for a single-port RAM with a shared bidirectional data pin.
// Buffers load/store requests in a FIFO and sequences contention-free RAM cycles.
module ram_bus_master #(
  parameter int ADDR_W      = 7,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = 1,
  parameter int FIFO_DEPTH  = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wre,
  inout  wire  [DATA_W-1:0] mem_data
);

  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int ENTRY_W = 1 + ADDR_W + DATA_W;
  localparam int CNT_W   = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD      = 3'd1,
    WSETUP  = 3'd2,
    WSTROBE = 3'd3,
    WHOLD   = 3'd4
  } state_t;

  logic [ENTRY_W-1:0] fifo_mem_r [FIFO_DEPTH];
  logic [PTR_W:0]     wr_ptr_r, rd_ptr_r;
  logic               full_s, empty_s, push_s, pop_s;
  logic               head_we_s;
  logic [ADDR_W-1:0]  head_addr_s;
  logic [DATA_W-1:0]  head_wdata_s;

  state_t             state_r, state_nxt;
  logic [CNT_W-1:0]   cnt_r, cnt_nxt;
  logic [ADDR_W-1:0]  mem_addr_r, addr_nxt;
  logic               mem_wre_r, wre_nxt;
  logic [DATA_W-1:0]  wdata_r, wdata_nxt;
  logic               rsp_valid_r, rsp_valid_nxt;
  logic [DATA_W-1:0]  rsp_rdata_r, rdata_nxt;

  // Full when the pointers differ only in their wrap bit.
  assign empty_s = (wr_ptr_r == rd_ptr_r);
  assign full_s  = (wr_ptr_r[PTR_W] != rd_ptr_r[PTR_W]) &&
                   (wr_ptr_r[PTR_W-1:0] == rd_ptr_r[PTR_W-1:0]);
  assign push_s  = req_valid && !full_s;
  assign {head_we_s, head_addr_s, head_wdata_s} = fifo_mem_r[rd_ptr_r[PTR_W-1:0]];

  assign req_ready = !full_s;
  assign busy      = (state_r != IDLE) || !empty_s;
  assign rsp_valid = rsp_valid_r;
  assign rsp_rdata = rsp_rdata_r;
  assign mem_addr  = mem_addr_r;
  assign mem_wre   = mem_wre_r;
  assign mem_data  = mem_wre_r ? wdata_r : {DATA_W{1'bz}};

  // Request storage; entry validity is tracked by the pointers alone.
  always_ff @(posedge clock) begin
    if (push_s) begin
      fifo_mem_r[wr_ptr_r[PTR_W-1:0]] <= {req_we, req_addr, req_wdata};
    end
  end

  // FIFO pointers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + (PTR_W+1)'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + (PTR_W+1)'(1);
    end
  end

  // Sequencer next-state and next register-output values.
  always_comb begin
    state_nxt     = state_r;
    cnt_nxt       = cnt_r;
    addr_nxt      = mem_addr_r;
    wre_nxt       = 1'b0;
    wdata_nxt     = wdata_r;
    rsp_valid_nxt = 1'b0;
    rdata_nxt     = rsp_rdata_r;
    pop_s         = 1'b0;
    case (state_r)
      IDLE: begin
        if (!empty_s) begin
          pop_s     = 1'b1;
          addr_nxt  = head_addr_s;
          wdata_nxt = head_wdata_s;
          cnt_nxt   = '0;
          state_nxt = head_we_s ? WSETUP : RD;
        end else begin
          state_nxt = IDLE;
        end
      end
      RD: begin
        if (cnt_r == CNT_LAST) begin
          rdata_nxt     = mem_data;
          rsp_valid_nxt = 1'b1;
          state_nxt     = IDLE;
        end else begin
          cnt_nxt = cnt_r + CNT_W'(1);
        end
      end
      WSETUP: begin
        wre_nxt   = 1'b1;
        cnt_nxt   = '0;
        state_nxt = WSTROBE;
      end
      WSTROBE: begin
        if (cnt_r == CNT_LAST) begin
          state_nxt = WHOLD;
        end else begin
          wre_nxt = 1'b1;
          cnt_nxt = cnt_r + CNT_W'(1);
        end
      end
      WHOLD:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Sequencer state and registered bus/response outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r     <= IDLE;
      cnt_r       <= '0;
      mem_addr_r  <= '0;
      mem_wre_r   <= 1'b0;
      wdata_r     <= '0;
      rsp_valid_r <= 1'b0;
      rsp_rdata_r <= '0;
    end else begin
      state_r     <= state_nxt;
      cnt_r       <= cnt_nxt;
      mem_addr_r  <= addr_nxt;
      mem_wre_r   <= wre_nxt;
      wdata_r     <= wdata_nxt;
      rsp_valid_r <= rsp_valid_nxt;
      rsp_rdata_r <= rdata_nxt;
    end
  end

endmodule

// File: tb/tb_ram_bus_master.sv
// Directed self-checking bench for ram_bus_master: one instance with one wait
// cycle, one with three, each attached to a behavioural 128x32 RAM.
module tb_ram_bus_master;

  logic        clock = 1'b0;
  logic        reset;
  logic        load_en;
  int          checks = 0;
  int          errors = 0;

  logic        req_valid, req_ready, req_we, rsp_valid, busy, mem_wre;
  logic [6:0]  req_addr, mem_addr;
  logic [31:0] req_wdata, rsp_rdata;
  wire  [31:0] mem_data;
  logic [31:0] ram [128];

  logic        req_valid_b, req_ready_b, req_we_b, rsp_valid_b, busy_b, mem_wre_b;
  logic [6:0]  req_addr_b, mem_addr_b;
  logic [31:0] req_wdata_b, rsp_rdata_b;
  wire  [31:0] mem_data_b;
  logic [31:0] ram_b [128];
  logic [31:0] rsp_q_b [$];
  logic        prev_wre_b = 1'b0;
  logic [6:0]  prev_addr_b = 7'd0;

  always #5 clock = ~clock;

  ram_bus_master #(.ADDR_W(7), .DATA_W(32), .WAIT_CYCLES(1), .FIFO_DEPTH(2)) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .busy(busy),
    .mem_addr(mem_addr), .mem_wre(mem_wre), .mem_data(mem_data));

  ram_bus_master #(.ADDR_W(7), .DATA_W(32), .WAIT_CYCLES(3), .FIFO_DEPTH(2)) dut_b (
    .clock(clock), .reset(reset), .req_valid(req_valid_b), .req_ready(req_ready_b),
    .req_we(req_we_b), .req_addr(req_addr_b), .req_wdata(req_wdata_b),
    .rsp_valid(rsp_valid_b), .rsp_rdata(rsp_rdata_b), .busy(busy_b),
    .mem_addr(mem_addr_b), .mem_wre(mem_wre_b), .mem_data(mem_data_b));

  // RAM models: drive the bus only while the master is not writing.
  assign mem_data   = mem_wre   ? 32'hzzzz_zzzz : ram[mem_addr];
  assign mem_data_b = mem_wre_b ? 32'hzzzz_zzzz : ram_b[mem_addr_b];

  always @(posedge clock) begin
    for (int i = 0; i < 128; i++) begin
      if (load_en) begin
        ram[i]   <= 32'(i);
        ram_b[i] <= 32'(i);
      end
    end
    if (!load_en && mem_wre)   ram[mem_addr]     <= mem_data;
    if (!load_en && mem_wre_b) ram_b[mem_addr_b] <= mem_data_b;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Bus monitor for the three-wait instance: address frozen across a strobe.
  always @(negedge clock) begin
    if (reset && mem_wre_b) begin
      chk("bus_drive_known", 64'($isunknown(mem_data_b)), 64'd0);
      if (prev_wre_b) chk("bus_addr_stable", 64'(mem_addr_b), 64'(prev_addr_b));
    end
    if (rsp_valid_b) rsp_q_b.push_back(rsp_rdata_b);
    prev_wre_b  <= mem_wre_b;
    prev_addr_b <= mem_addr_b;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_write(input logic [6:0] a, input logic [31:0] d);
    req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_wdata = d;
    tick();
    req_valid = 1'b0;
    tick();
    chk("wsetup_wre", 64'(mem_wre), 64'd0);
    chk("wsetup_addr", 64'(mem_addr), 64'(a));
    chk("wsetup_busy", 64'(busy), 64'd1);
    tick();
    chk("wstrobe_wre", 64'(mem_wre), 64'd1);
    chk("wstrobe_data", 64'(mem_data), 64'(d));
    tick();
    chk("whold_wre", 64'(mem_wre), 64'd0);
    chk("whold_addr", 64'(mem_addr), 64'(a));
    chk("ram_written", 64'(ram[a]), 64'(d));
    tick();
    chk("write_done_busy", 64'(busy), 64'd0);
  endtask

  task automatic do_read(input logic [6:0] a, input logic [31:0] exp);
    req_valid = 1'b1; req_we = 1'b0; req_addr = a; req_wdata = 32'h0;
    tick();
    req_valid = 1'b0;
    tick();
    chk("rd_early_valid", 64'(rsp_valid), 64'd0);
    chk("rd_addr", 64'(mem_addr), 64'(a));
    chk("rd_wre", 64'(mem_wre), 64'd0);
    tick();
    chk("rd_valid", 64'(rsp_valid), 64'd1);
    chk("rd_data", 64'(rsp_rdata), 64'(exp));
    tick();
    chk("rd_pulse_end", 64'(rsp_valid), 64'd0);
  endtask

  task automatic push_b(input logic we, input logic [6:0] a, input logic [31:0] d);
    int n;
    n = 0;
    req_valid_b = 1'b1; req_we_b = we; req_addr_b = a; req_wdata_b = d;
    while (!req_ready_b && n < 50) begin
      tick();
      n++;
    end
    chk("push_b_timeout", 64'(n < 50), 64'd1);
    tick();
    req_valid_b = 1'b0;
  endtask

  initial begin
    int n;
    reset = 1'b1; load_en = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = 7'd0; req_wdata = 32'd0;
    req_valid_b = 1'b0; req_we_b = 1'b0; req_addr_b = 7'd0; req_wdata_b = 32'd0;
    #2 reset = 1'b0;
    tick();
    tick();
    chk("rst_ready", 64'(req_ready), 64'd1);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rdata", 64'(rsp_rdata), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_addr", 64'(mem_addr), 64'd0);
    chk("rst_wre", 64'(mem_wre), 64'd0);
    reset = 1'b1; load_en = 1'b0;
    tick();

    // Single write then read, then response hold.
    do_write(7'd5, 32'h2008_1414);
    do_read(7'd5, 32'h2008_1414);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("hold_valid", 64'(rsp_valid), 64'd0);
      chk("hold_rdata", 64'(rsp_rdata), 64'h2008_1414);
    end

    // FIFO full: a leading write keeps the sequencer busy while reads 1,2,3 queue.
    req_valid = 1'b1; req_we = 1'b1; req_addr = 7'd9; req_wdata = 32'h99;
    chk("ff_ready0", 64'(req_ready), 64'd1);
    tick();
    req_we = 1'b0; req_addr = 7'd1;
    chk("ff_ready1", 64'(req_ready), 64'd1);
    tick();
    req_addr = 7'd2;
    chk("ff_ready2", 64'(req_ready), 64'd1);
    tick();
    req_addr = 7'd3;
    chk("ff_full_a", 64'(req_ready), 64'd0);
    tick();
    chk("ff_full_b", 64'(req_ready), 64'd0);
    tick();
    chk("ff_full_c", 64'(req_ready), 64'd0);
    tick();
    chk("ff_after_pop", 64'(req_ready), 64'd1);
    tick();
    req_valid = 1'b0;
    chk("ff_rsp1_valid", 64'(rsp_valid), 64'd1);
    chk("ff_rsp1_data", 64'(rsp_rdata), 64'd1);
    chk("ff_full_again", 64'(req_ready), 64'd0);
    tick();
    chk("ff_gap", 64'(rsp_valid), 64'd0);
    tick();
    chk("ff_rsp2_valid", 64'(rsp_valid), 64'd1);
    chk("ff_rsp2_data", 64'(rsp_rdata), 64'd2);
    tick();
    tick();
    chk("ff_rsp3_valid", 64'(rsp_valid), 64'd1);
    chk("ff_rsp3_data", 64'(rsp_rdata), 64'd3);
    tick();
    chk("ff_idle", 64'(busy), 64'd0);

    // Wrap and limits.
    do_write(7'h7F, 32'hFFFF_FFFF);
    do_read(7'h7F, 32'hFFFF_FFFF);
    do_read(7'h00, 32'h0000_0000);

    // Mixed write/read traffic on the three-wait instance.
    push_b(1'b1, 7'h7F, 32'hA5A5_0001);
    push_b(1'b0, 7'h7F, 32'h0);
    push_b(1'b1, 7'h00, 32'h5A5A_0002);
    push_b(1'b0, 7'h00, 32'h0);
    n = 0;
    while (busy_b && n < 100) begin
      tick();
      n++;
    end
    tick();
    chk("mixed_timeout", 64'(n < 100), 64'd1);
    chk("mixed_rsp_count", 64'(rsp_q_b.size()), 64'd2);
    chk("mixed_rsp0", 64'((rsp_q_b.size() > 0) ? rsp_q_b[0] : 32'hDEAD_BEEF), 64'hA5A5_0001);
    chk("mixed_rsp1", 64'((rsp_q_b.size() > 1) ? rsp_q_b[1] : 32'hDEAD_BEEF), 64'h5A5A_0002);
    chk("mixed_ram7f", 64'(ram_b[7'h7F]), 64'hA5A5_0001);
    chk("mixed_ram00", 64'(ram_b[7'h00]), 64'h5A5A_0002);

    // Reset during a strobe with a read still queued behind it.
    req_valid = 1'b1; req_we = 1'b1; req_addr = 7'h10; req_wdata = 32'hABCD;
    tick();
    req_we = 1'b0;
    tick();
    req_valid = 1'b0;
    tick();
    chk("mid_strobe_wre", 64'(mem_wre), 64'd1);
    reset = 1'b0;
    #1;
    chk("mid_rst_wre", 64'(mem_wre), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_ready", 64'(req_ready), 64'd1);
    chk("mid_rst_valid", 64'(rsp_valid), 64'd0);
    tick();
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("post_rst_no_rsp", 64'(rsp_valid), 64'd0);
      chk("post_rst_idle", 64'(busy), 64'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
